arima_result_logger: RTL and testbench

// Write-side counterpart of the ARIMA detector's result port: captures every
// (address_w, prediction_o, label) strobed by wren into an internal result RAM.

---
 rtl/arima_result_logger.sv | 139 +++++++++++++
 tb/tb_arima_result_logger.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arima_result_logger.sv
// Result capture RAM for the ARIMA detector: stores (prediction, label) per index,
// keeps write/anomaly statistics and offers a registered one-cycle readback port.
module arima_result_logger #(
  parameter int N     = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wren,
  input  logic [31:0]   address_w,
  input  logic [N-1:0]  prediction_in,
  input  logic          label_in,
  input  logic          clear,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [N-1:0]  rd_data,
  output logic          rd_label,
  output logic [15:0]   wr_count,
  output logic [15:0]   anomaly_count,
  output logic [AW-1:0] last_anom_addr,
  output logic          range_err,
  output logic          busy
);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_sweep_idx, w_sweep_idx_next;
  logic          w_in_range, w_accept, w_bad_addr, w_we, w_busy;
  logic [AW-1:0] w_waddr;
  logic [N:0]    w_wdata;

  // Each entry packs {label, prediction}; single write port, single registered read port.
  logic [N:0]    r_mem [DEPTH];

  logic          r_rd_valid;
  logic [N-1:0]  r_rd_data;
  logic          r_rd_label;
  logic [15:0]   r_wr_count, r_anomaly_count;
  logic [AW-1:0] r_last_anom_addr;
  logic          r_range_err;

  assign w_in_range = (address_w < 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_CLEAR;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sweep_idx <= w_sweep_idx_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_sweep_idx_next = r_sweep_idx;
    w_busy           = 1'b0;
    w_accept         = 1'b0;
    w_bad_addr       = 1'b0;
    w_we             = 1'b0;
    w_waddr          = address_w[AW-1:0];
    w_wdata          = {label_in, prediction_in};
    case (r_state)
      ST_CLEAR: begin
        // Held in reset the sweep is frozen at entry 0 and busy reads low.
        w_busy  = ~reset;
        w_we    = ~reset;
        w_waddr = r_sweep_idx;
        w_wdata = '0;
        if (clear) begin
          w_sweep_idx_next = '0;
        end else begin
          w_sweep_idx_next = r_sweep_idx + 1'b1;
          if (r_sweep_idx == AW'(DEPTH - 1)) w_state_next = ST_READY;
        end
      end
      ST_READY: begin
        if (clear) begin
          w_state_next     = ST_CLEAR;
          w_sweep_idx_next = '0;
        end else if (wren && !reset) begin
          if (w_in_range) begin
            w_accept = 1'b1;
            w_we     = 1'b1;
          end else begin
            w_bad_addr = 1'b1;
          end
        end
      end
      default: w_state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_label <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) {r_rd_label, r_rd_data} <= r_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr_count       <= '0;
      r_anomaly_count  <= '0;
      r_last_anom_addr <= '0;
      r_range_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
        if (label_in) begin
          if (r_anomaly_count != 16'hFFFF) r_anomaly_count <= r_anomaly_count + 16'd1;
          r_last_anom_addr <= address_w[AW-1:0];
        end
      end
      if (w_bad_addr) r_range_err <= 1'b1;
    end
  end

  assign rd_valid       = r_rd_valid;
  assign rd_data        = r_rd_data;
  assign rd_label       = r_rd_label;
  assign wr_count       = r_wr_count;
  assign anomaly_count  = r_anomaly_count;
  assign last_anom_addr = r_last_anom_addr;
  assign range_err      = r_range_err;
  assign busy           = w_busy;

endmodule

// File: tb/tb_arima_result_logger.sv
// Bench for arima_result_logger: directed scenarios plus random traffic, all checked
// every cycle against an array/counter model of the logger's behaviour.
module tb_arima_result_logger;
  localparam int N = 32;
  localparam int DEPTH = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wren = 1'b0;
  logic [31:0]   address_w = '0;
  logic [N-1:0]  prediction_in = '0;
  logic          label_in = 1'b0;
  logic          clear = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [N-1:0]  rd_data;
  logic          rd_label;
  logic [15:0]   wr_count, anomaly_count;
  logic [AW-1:0] last_anom_addr;
  logic          range_err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  arima_result_logger #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wren(wren), .address_w(address_w),
    .prediction_in(prediction_in), .label_in(label_in), .clear(clear),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_label(rd_label), .wr_count(wr_count), .anomaly_count(anomaly_count),
    .last_anom_addr(last_anom_addr), .range_err(range_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory array, plain counters, and a count of sweep cycles left.
  logic [N-1:0]  m_mem [DEPTH];
  logic          m_lab [DEPTH];
  int            m_sweep_left = DEPTH;
  logic          m_rd_valid = 1'b0;
  logic [N-1:0]  m_rd_data = '0;
  logic          m_rd_label = 1'b0;
  int            m_wr = 0, m_an = 0;
  int            m_last = 0;
  logic          m_rerr = 1'b0;
  bit            m_ready;

  initial for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_lab[i] = 1'b0; end

  always @(posedge clk) begin
    if (reset) begin
      m_rd_valid = 1'b0; m_rd_data = '0; m_rd_label = 1'b0;
      m_wr = 0; m_an = 0; m_last = 0; m_rerr = 1'b0;
      m_sweep_left = DEPTH;
    end else begin
      m_ready = (m_sweep_left == 0);
      m_rd_valid = rd_req;
      if (rd_req) begin
        m_rd_data  = m_mem[rd_addr];
        m_rd_label = m_lab[rd_addr];
      end
      if (!m_ready) begin
        m_mem[DEPTH - m_sweep_left] = '0;
        m_lab[DEPTH - m_sweep_left] = 1'b0;
        m_sweep_left--;
      end
      if (clear) begin
        m_wr = 0; m_an = 0; m_last = 0; m_rerr = 1'b0;
        m_sweep_left = DEPTH;
      end else if (m_ready && wren) begin
        if (address_w < 32'(DEPTH)) begin
          m_mem[address_w % DEPTH] = prediction_in;
          m_lab[address_w % DEPTH] = label_in;
          if (m_wr < 65535) m_wr++;
          if (label_in) begin
            if (m_an < 65535) m_an++;
            m_last = address_w % DEPTH;
          end
        end else begin
          m_rerr = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    check("rd_data", 64'(rd_data), 64'(m_rd_data));
    check("rd_label", 64'(rd_label), 64'(m_rd_label));
    check("wr_count", 64'(wr_count), 64'(m_wr));
    check("anomaly_count", 64'(anomaly_count), 64'(m_an));
    check("last_anom_addr", 64'(last_anom_addr), 64'(m_last));
    check("range_err", 64'(range_err), 64'(m_rerr));
    check("busy", 64'(busy), 64'(!reset && m_sweep_left > 0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      if (busy) cnt++;
      else if (cnt > 0) break;
      tick();
    end
  endtask

  int bcnt;
  logic [31:0] a;

  initial begin
    // 1: reset one cycle, sweep length, idle read of index 5
    tick();
    reset = 1'b0;
    #1;
    count_busy(bcnt);
    check("busy_cycles_after_reset", 64'(bcnt), 64'd256);
    rd_req = 1'b1; rd_addr = 8'd5;
    tick();
    rd_req = 1'b0;
    check("t1_rd_valid", 64'(rd_valid), 64'd1);
    check("t1_rd_data", 64'(rd_data), 64'd0);
    check("t1_rd_label", 64'(rd_label), 64'd0);
    tick();
    check("t1_rd_valid_drop", 64'(rd_valid), 64'd0);

    // 2: two writes then back-to-back reads
    wren = 1'b1; address_w = 32'd3; prediction_in = 32'h0000_8000; label_in = 1'b0;
    tick();
    address_w = 32'd4; prediction_in = 32'hFFFF_C000; label_in = 1'b1;
    tick();
    wren = 1'b0;
    check("t2_wr_count", 64'(wr_count), 64'd2);
    check("t2_anomaly_count", 64'(anomaly_count), 64'd1);
    check("t2_last_anom", 64'(last_anom_addr), 64'd4);
    rd_req = 1'b1; rd_addr = 8'd3;
    tick();
    check("t2_rd3_data", 64'(rd_data), 64'h8000);
    check("t2_rd3_label", 64'(rd_label), 64'd0);
    rd_addr = 8'd4;
    tick();
    rd_req = 1'b0;
    check("t2_rd4_data", 64'(rd_data), 64'hFFFF_C000);
    check("t2_rd4_label", 64'(rd_label), 64'd1);

    // 3: out-of-range write
    wren = 1'b1; address_w = 32'd256; prediction_in = 32'hDEAD_BEEF; label_in = 1'b1;
    tick();
    wren = 1'b0;
    check("t3_range_err", 64'(range_err), 64'd1);
    check("t3_wr_count", 64'(wr_count), 64'd2);
    rd_req = 1'b1; rd_addr = 8'd0;
    tick();
    rd_req = 1'b0;
    check("t3_idx0", 64'(rd_data), 64'd0);

    // 4: same-cycle write and read of index 7 returns old content
    wren = 1'b1; address_w = 32'd7; prediction_in = 32'h1234; label_in = 1'b0;
    rd_req = 1'b1; rd_addr = 8'd7;
    tick();
    wren = 1'b0;
    check("t4_read_first", 64'(rd_data), 64'd0);
    tick();
    rd_req = 1'b0;
    check("t4_read_new", 64'(rd_data), 64'h1234);

    // random traffic, occasional clears and out-of-range writes
    for (int i = 0; i < 3000; i++) begin
      wren = ($urandom_range(0, 2) != 0);
      a = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 15) == 0) a = $urandom | 32'h0000_0100;
      address_w = a;
      prediction_in = $urandom;
      label_in = $urandom_range(0, 1);
      rd_req = $urandom_range(0, 1);
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      clear = ($urandom_range(0, 299) == 0);
      tick();
    end
    clear = 1'b0; wren = 1'b0; rd_req = 1'b0;
    for (int c = 0; c < 300 && busy; c++) tick();

    // 5: clear zeroes stats, sweep ignores writes, RAM reads back zero
    wren = 1'b1; address_w = 32'd9; prediction_in = 32'h55; label_in = 1'b1;
    tick();
    wren = 1'b1; address_w = 32'd300;
    tick();
    clear = 1'b1; wren = 1'b1; address_w = 32'd10;
    tick();
    clear = 1'b0;
    check("t5_wr_count_cleared", 64'(wr_count), 64'd0);
    check("t5_range_err_cleared", 64'(range_err), 64'd0);
    check("t5_busy", 64'(busy), 64'd1);
    bcnt = 0;
    for (int c = 0; c < 400; c++) begin
      if (busy) bcnt++;
      else break;
      wren = $urandom_range(0, 1);
      address_w = $urandom_range(0, DEPTH - 1);
      label_in = 1'b1;
      tick();
    end
    wren = 1'b0;
    check("t5_busy_cycles", 64'(bcnt), 64'd256);
    check("t5_wr_count_after", 64'(wr_count), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_req = 1'b1; rd_addr = AW'(i);
      tick();
      check("t5_zero_data", 64'({rd_label, rd_data}), 64'd0);
    end
    rd_req = 1'b0;

    // 6: saturation
    wren = 1'b1; label_in = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      address_w = $urandom_range(0, DEPTH - 1);
      prediction_in = $urandom;
      tick();
    end
    wren = 1'b0;
    tick();
    check("t6_wr_sat", 64'(wr_count), 64'hFFFF);
    check("t6_anom_sat", 64'(anomaly_count), 64'hFFFF);

    // reset mid-read drops rd_valid and restarts the sweep
    rd_req = 1'b1; rd_addr = 8'd1; reset = 1'b1;
    tick();
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    reset = 1'b0; rd_req = 1'b0;
    #1;
    count_busy(bcnt);
    check("busy_cycles_after_rst2", 64'(bcnt), 64'd256);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
